// File: rtl/serial_word_input.sv
// UART receiver that assembles four bytes (little-endian) into a 32-bit word
// and queues completed words in a 4-entry FIFO with ready-to-receive flow control.
module serial_word_input #(
  parameter int clock_frequency = 50000000,
  parameter int baud_rate       = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        rtr,
  output logic [31:0] out1,
  output logic        out1_stb,
  input  logic        out1_ack,
  output logic        framing_error,
  output logic        overflow
);

  localparam int CPB  = clock_frequency / baud_rate;
  localparam int HALF = CPB / 2;
  localparam int TW   = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [TW-1:0] BIT_LOAD   = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic          rx_meta_q;
  logic          rx_sync_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   word_q, word_d;
  logic          push_s;
  logic [31:0]   push_word_s;
  logic          fe_s;
  logic          timer_exp_s;

  logic [31:0]   mem_q [4];
  logic [1:0]    wr_ptr_q;
  logic [1:0]    rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic          pop_s;
  logic          push_ok_s;
  logic          ovf_s;
  logic          rtr_q;
  logic          framing_error_q;
  logic          overflow_q;

  assign timer_exp_s = (timer_q == TIMER_ZERO);

  // Receive FSM: bit timing, byte shifting and little-endian word assembly.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    push_s      = 1'b0;
    push_word_s = {shift_q, word_q};
    fe_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          timer_d = HALF_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_exp_s) begin
          if (!rx_sync_q) begin
            state_d   = ST_DATA;
            timer_d   = BIT_LOAD;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_DATA: begin
        if (timer_exp_s) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          timer_d = BIT_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_STOP: begin
        if (timer_exp_s) begin
          state_d = ST_IDLE;
          if (rx_sync_q) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    word_d[7:0]   = shift_q;
              2'd1:    word_d[15:8]  = shift_q;
              2'd2:    word_d[23:16] = shift_q;
              default: push_s        = 1'b1;
            endcase
          end else begin
            fe_s       = 1'b1;
            byte_cnt_d = 2'd0;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO control: a full FIFO still takes a word when the head leaves in the same cycle.
  always_comb begin
    pop_s     = (count_q != 3'd0) && out1_ack;
    push_ok_s = push_s && ((count_q != 3'd4) || pop_s);
    ovf_s     = push_s && !push_ok_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State, FIFO and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q       <= 1'b1;
      rx_sync_q       <= 1'b1;
      state_q         <= ST_IDLE;
      timer_q         <= TIMER_ZERO;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'd0;
      byte_cnt_q      <= 2'd0;
      word_q          <= 24'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 32'd0;
      end
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      count_q         <= 3'd0;
      rtr_q           <= 1'b0;
      framing_error_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      rx_meta_q       <= rx;
      rx_sync_q       <= rx_meta_q;
      state_q         <= state_d;
      timer_q         <= timer_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      byte_cnt_q      <= byte_cnt_d;
      word_q          <= word_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_word_s;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q         <= count_d;
      // Deassert at three words so one more in-flight word still fits.
      rtr_q           <= (count_d <= 3'd2);
      framing_error_q <= fe_s;
      overflow_q      <= ovf_s;
    end
  end

  assign out1          = mem_q[rd_ptr_q];
  assign out1_stb      = (count_q != 3'd0);
  assign rtr           = rtr_q;
  assign framing_error = framing_error_q;
  assign overflow      = overflow_q;

endmodule

// File: doc/serial_word_input.md
SERIAL_WORD_INPUT -- requirements
Module: serial_word_input

Interface
REQ-001 The block SHALL have parameter clock_frequency, default 50000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 115200, meaning the serial line bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning reset, synchronous, active-low.
REQ-005 The block SHALL have port rx, input, 1 bit, meaning the asynchronous serial line, idle high.
REQ-006 The block SHALL have port rtr, output, 1 bit, meaning ready-to-receive to the remote transmitter's cts; 1 permits sending.
REQ-007 The block SHALL have port out1, output, 32 bits, meaning the assembled word at the FIFO head.
REQ-008 The block SHALL have port out1_stb, output, 1 bit, meaning out1 is valid.
REQ-009 The block SHALL have port out1_ack, input, 1 bit, meaning the consumer accepts out1.
REQ-010 The block SHALL have port framing_error, output, 1 bit, meaning a one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overflow, output, 1 bit, meaning a one-cycle pulse when a completed word is dropped.

Function
REQ-012 The block SHALL define CPB = clock_frequency / baud_rate, truncating integer division (434 at the defaults).
REQ-013 The block SHALL pass rx through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-014 The receive FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-015 IDLE: synced rx = 0 SHALL move the FSM to START and load the bit timer for CPB/2 cycles.
REQ-016 START at timer expiry: synced rx = 0 SHALL move to DATA with timer = CPB; rx = 1 SHALL return to IDLE as a glitch, with no error.
REQ-017 DATA SHALL sample 8 bits, LSB first, one per CPB cycles, then move to STOP with timer = CPB.
REQ-018 STOP at expiry, rx = 1: the byte SHALL be valid and the FSM SHALL return to IDLE in the same cycle.
REQ-019 STOP at expiry, rx = 0: framing_error SHALL pulse for 1 cycle, the byte SHALL be discarded, byte_count SHALL clear to 0 (partial word discarded), and the FSM SHALL return to IDLE.
REQ-020 Each valid byte SHALL be written to out-word bits [8k+7:8k], where k = byte_count, 0..3 (little-endian), and byte_count SHALL then increment.
REQ-021 On the valid byte with k = 3, the assembled word SHALL be pushed to the FIFO and byte_count SHALL wrap to 0.
REQ-022 The FIFO SHALL hold 4 words, with 2-bit read/write pointers that wrap naturally and a 3-bit count, 0..4.
REQ-023 out1_stb SHALL equal (count != 0), and out1 SHALL equal the head entry; both SHALL be registered or directly derived from registers.
REQ-024 A pop SHALL occur on any cycle with out1_stb = 1 and out1_ack = 1; out1_ack while empty SHALL have no effect.
REQ-025 A push SHALL be accepted if count < 4, or if count = 4 and a pop occurs in the same cycle.
REQ-026 A push that is not accepted SHALL drop the word, pulse overflow for 1 cycle and leave the FIFO unchanged.
REQ-027 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-028 rtr SHALL be registered, with next value (next_count <= 2), so that one further word can still arrive after deassertion.
REQ-029 Latency: out1_stb SHALL rise on the clock edge after the STOP sample of byte 3 when the FIFO was empty.
REQ-030 Data received while rtr = 0 SHALL still be accepted normally.

Reset
REQ-031 When rst_n = 0 at a clk edge, the FSM SHALL go to IDLE, and the timer, byte_count, pointers and count SHALL go to 0.
REQ-032 When rst_n = 0 at a clk edge, out1 SHALL go to 0, out1_stb SHALL go to 0, rtr SHALL go to 0, framing_error SHALL go to 0, overflow SHALL go to 0, and the synchronizer SHALL go to 1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame and any partial word without an error pulse.
REQ-034 rtr SHALL rise on the first clk edge after rst_n returns to 1.

Verification
REQ-035 The bench SHALL cover: bytes 0x78, 0x56, 0x34, 0x12 at 115200 baud with 50 MHz clk -> one word out1 = 0x12345678, out1_stb high until ack, framing_error and overflow never set.
REQ-036 The bench SHALL cover: 5 words sent with out1_ack held 0 -> rtr falls once count reaches 3, the 5th word is dropped with one overflow pulse, and the 4 popped words appear in order.
REQ-037 The bench SHALL cover: byte 0xAA with the stop bit forced low after 2 good bytes -> framing_error pulses once; the next 4 good bytes 0x01, 0x02, 0x03, 0x04 give out1 = 0x04030201.
REQ-038 The bench SHALL cover: a 100-cycle low glitch on idle rx -> no state beyond START, no byte, no error.
REQ-039 The bench SHALL cover: FIFO full with out1_ack = 1 on the same cycle as the 4th byte's STOP sample -> no overflow, count stays 4, and the new word appears last.
REQ-040 The bench SHALL cover: rst_n pulsed low during bit 4 of byte 2 -> all outputs are 0; after release, a fresh 4-byte word is assembled correctly from byte lane 0.
